ysyx_22040632_csr: RTL and testbench
====================================

YSYX_22040632_CSR -- requirements
Module: ysyx_22040632_csr

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width for PC and CSR data.
REQ-002 SHALL have parameter MSTATUS_RST, default 'h1800, meaning mstatus reset value (MPP=2'b11).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port wen_ecall2csr  in  1  ecall retiring this cycle.
REQ-006 SHALL have port NO2csr  in  XLEN  trap cause written to mcause on ecall.
REQ-007 SHALL have port pc2csr  in  XLEN  PC of ecall, written to mepc.
REQ-008 SHALL have port wen_csr2csr  in  1  Zicsr write retiring this cycle.
REQ-009 SHALL have port csr_addr_write2csr  in  12  target CSR address.
REQ-010 SHALL have port csr_data_write2csr  in  XLEN  write data.
REQ-011 SHALL have port wen_mstatus_ecall2csr  in  1  apply ecall mstatus transform.
REQ-012 SHALL have port wen_mstatus_mret2csr  in  1  apply mret mstatus transform.
REQ-013 SHALL have port retire_i  in  1  one instruction retired this cycle.
REQ-014 SHALL have port csr_addr_read_i  in  12  ID-stage read address.
REQ-015 SHALL have port csr_rdata_o  out  XLEN  ID-stage read data, combinational.
REQ-016 SHALL have port mtvec_o  out  XLEN  trap target for ecall redirect.
REQ-017 SHALL have port mepc_o  out  XLEN  return target for mret redirect.

Function
REQ-018 SHALL implement mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02; all XLEN wide.
REQ-019 SHALL return 0 for reads of any other address and ignore writes to it.
REQ-020 SHALL, on wen_csr2csr, write csr_data_write2csr to the addressed CSR at the next edge.
REQ-021 SHALL, on wen_ecall2csr, load mepc<=pc2csr and mcause<=NO2csr at the next edge.
REQ-022 SHALL, on wen_mstatus_ecall2csr, set MPIE(bit7)<=MIE(bit3), MIE<=0, MPP(bits12:11)<=2'b11; other bits held.
REQ-023 SHALL, on wen_mstatus_mret2csr, set MIE<=MPIE, MPIE<=1, MPP<=2'b11; other bits held.
REQ-024 SHALL give trap updates (REQ-021..023) priority over a same-cycle wen_csr2csr to the same CSR; writes to non-conflicting CSRs SHALL both take effect.
REQ-025 SHALL give the ecall transform priority over the mret transform when both asserted.
REQ-026 SHALL increment mcycle by 1 every cycle out of reset, wrapping modulo 2^XLEN.
REQ-027 SHALL increment minstret by 1 in cycles with retire_i=1, wrapping modulo 2^XLEN.
REQ-028 SHALL, when wen_csr2csr targets mcycle or minstret, load the written value instead of incrementing that cycle.
REQ-029 SHALL bypass: when csr_addr_read_i equals a CSR being written this cycle, csr_rdata_o SHALL show the value that CSR holds after the edge (including trap priority and counter rules).
REQ-030 SHALL bypass mtvec_o and mepc_o likewise, so a same-cycle CSR write or ecall to mtvec/mepc is visible.
REQ-031 SHALL have zero-cycle read latency and one-cycle write latency.

Reset
REQ-032 SHALL, with rst_n=0 at a rising edge, set mstatus=MSTATUS_RST and mtvec, mepc, mcause, mcycle, minstret=0; all write inputs ignored that cycle.
REQ-033 SHALL drive csr_rdata_o, mtvec_o, mepc_o from reset values (bypass active) in the first cycle after reset release; mcycle=1 after the first non-reset edge.
REQ-034 SHALL abort counting and any pending write when rst_n falls mid-operation; no partial update persists.

Verification
REQ-035 SHALL cover: write mtvec=0x8000_0100, next cycle read 0x305 -> csr_rdata_o=0x8000_0100, mtvec_o=0x8000_0100.
REQ-036 SHALL cover: mstatus=0x1808, ecall with pc=0x8000_0040, NO=11 -> mepc=0x8000_0040, mcause=11, mstatus=0x1880.
REQ-037 SHALL cover: following mret -> mstatus=0x1888; mepc_o=0x8000_0040.
REQ-038 SHALL cover: same cycle ecall(pc=0x10) and csr write mepc=0x20 -> mepc=0x10; csr write mcause=5 with ecall NO=11 -> mcause=11.
REQ-039 SHALL cover: mcycle written 2^XLEN-1 then two idle cycles -> reads 0 then 1; minstret unchanged while retire_i=0.
REQ-040 SHALL cover: read 0x305 while writing mtvec=0x44 same cycle -> csr_rdata_o=0x44; read 0x7C0 -> 0.

Source files
------------

// File: rtl/ysyx_22040632_csr.sv
// Machine-mode CSR file: mstatus/mtvec/mepc/mcause plus free-running mcycle/minstret.
// Reads are combinational and bypass same-cycle updates so ID sees post-edge values.
module ysyx_22040632_csr #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] MSTATUS_RST = 'h1800
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wen_ecall2csr,
    input  logic [XLEN-1:0] NO2csr,
    input  logic [XLEN-1:0] pc2csr,
    input  logic            wen_csr2csr,
    input  logic [11:0]     csr_addr_write2csr,
    input  logic [XLEN-1:0] csr_data_write2csr,
    input  logic            wen_mstatus_ecall2csr,
    input  logic            wen_mstatus_mret2csr,
    input  logic            retire_i,
    input  logic [11:0]     csr_addr_read_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o
);

    localparam logic [11:0] AddrMstatus  = 12'h300;
    localparam logic [11:0] AddrMtvec    = 12'h305;
    localparam logic [11:0] AddrMepc     = 12'h341;
    localparam logic [11:0] AddrMcause   = 12'h342;
    localparam logic [11:0] AddrMcycle   = 12'hB00;
    localparam logic [11:0] AddrMinstret = 12'hB02;

    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mcycle_q, mcycle_d;
    logic [XLEN-1:0] minstret_q, minstret_d;

    logic wr_mstatus, wr_mtvec, wr_mepc, wr_mcause, wr_mcycle, wr_minstret;

    always_comb begin
        wr_mstatus  = wen_csr2csr && (csr_addr_write2csr == AddrMstatus);
        wr_mtvec    = wen_csr2csr && (csr_addr_write2csr == AddrMtvec);
        wr_mepc     = wen_csr2csr && (csr_addr_write2csr == AddrMepc);
        wr_mcause   = wen_csr2csr && (csr_addr_write2csr == AddrMcause);
        wr_mcycle   = wen_csr2csr && (csr_addr_write2csr == AddrMcycle);
        wr_minstret = wen_csr2csr && (csr_addr_write2csr == AddrMinstret);
    end

    // Trap-side updates win over a software write to the same CSR.
    always_comb begin
        mstatus_d = mstatus_q;
        if (wen_mstatus_ecall2csr) begin
            mstatus_d[7]     = mstatus_q[3];
            mstatus_d[3]     = 1'b0;
            mstatus_d[12:11] = 2'b11;
        end else if (wen_mstatus_mret2csr) begin
            mstatus_d[3]     = mstatus_q[7];
            mstatus_d[7]     = 1'b1;
            mstatus_d[12:11] = 2'b11;
        end else if (wr_mstatus) begin
            mstatus_d = csr_data_write2csr;
        end
    end

    always_comb begin
        mtvec_d = wr_mtvec ? csr_data_write2csr : mtvec_q;

        mepc_d = mepc_q;
        if (wen_ecall2csr) begin
            mepc_d = pc2csr;
        end else if (wr_mepc) begin
            mepc_d = csr_data_write2csr;
        end

        mcause_d = mcause_q;
        if (wen_ecall2csr) begin
            mcause_d = NO2csr;
        end else if (wr_mcause) begin
            mcause_d = csr_data_write2csr;
        end

        mcycle_d = wr_mcycle ? csr_data_write2csr : mcycle_q + XLEN'(1);

        minstret_d = minstret_q;
        if (wr_minstret) begin
            minstret_d = csr_data_write2csr;
        end else if (retire_i) begin
            minstret_d = minstret_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q  <= MSTATUS_RST;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // Non-counter _d equals _q when nothing targets it, so _d is a safe bypass source.
    // Counters only bypass on an explicit write; otherwise the current count is shown.
    always_comb begin
        case (csr_addr_read_i)
            AddrMstatus:  csr_rdata_o = mstatus_d;
            AddrMtvec:    csr_rdata_o = mtvec_d;
            AddrMepc:     csr_rdata_o = mepc_d;
            AddrMcause:   csr_rdata_o = mcause_d;
            AddrMcycle:   csr_rdata_o = wr_mcycle ? csr_data_write2csr : mcycle_q;
            AddrMinstret: csr_rdata_o = wr_minstret ? csr_data_write2csr : minstret_q;
            default:      csr_rdata_o = '0;
        endcase
    end

    assign mtvec_o = mtvec_d;
    assign mepc_o  = mepc_d;

endmodule

// File: tb/tb_ysyx_22040632_csr.sv
// Scoreboard bench for ysyx_22040632_csr: expectations queued per cycle, compared at negedge.
module tb_ysyx_22040632_csr;

    localparam int unsigned XLEN = 64;

    localparam int KRdata = 0;
    localparam int KMtvec = 1;
    localparam int KMepc  = 2;

    typedef struct {
        string           tag;
        int              kind;
        int              cyc;
        logic [XLEN-1:0] val;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wen_ecall2csr;
    logic [XLEN-1:0] NO2csr;
    logic [XLEN-1:0] pc2csr;
    logic            wen_csr2csr;
    logic [11:0]     csr_addr_write2csr;
    logic [XLEN-1:0] csr_data_write2csr;
    logic            wen_mstatus_ecall2csr;
    logic            wen_mstatus_mret2csr;
    logic            retire_i;
    logic [11:0]     csr_addr_read_i;
    logic [XLEN-1:0] csr_rdata_o;
    logic [XLEN-1:0] mtvec_o;
    logic [XLEN-1:0] mepc_o;

    exp_t sb[$];
    int   cur = 0;
    int   total = 0;
    int   bad = 0;

    ysyx_22040632_csr #(
        .XLEN        (XLEN),
        .MSTATUS_RST (64'h1800)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .wen_ecall2csr         (wen_ecall2csr),
        .NO2csr                (NO2csr),
        .pc2csr                (pc2csr),
        .wen_csr2csr           (wen_csr2csr),
        .csr_addr_write2csr    (csr_addr_write2csr),
        .csr_data_write2csr    (csr_data_write2csr),
        .wen_mstatus_ecall2csr (wen_mstatus_ecall2csr),
        .wen_mstatus_mret2csr  (wen_mstatus_mret2csr),
        .retire_i              (retire_i),
        .csr_addr_read_i       (csr_addr_read_i),
        .csr_rdata_o           (csr_rdata_o),
        .mtvec_o               (mtvec_o),
        .mepc_o                (mepc_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                            input logic [XLEN-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int kind, input logic [XLEN-1:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.cyc  = cur;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Start a new cycle just after the edge with all request inputs idle.
    task automatic cycle_begin();
        @(posedge clk);
        #1;
        cur++;
        wen_ecall2csr         = 1'b0;
        NO2csr                = '0;
        pc2csr                = '0;
        wen_csr2csr           = 1'b0;
        csr_addr_write2csr    = '0;
        csr_data_write2csr    = '0;
        wen_mstatus_ecall2csr = 1'b0;
        wen_mstatus_mret2csr  = 1'b0;
        retire_i              = 1'b0;
        csr_addr_read_i       = 12'h7C0;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [XLEN-1:0] data);
        wen_csr2csr        = 1'b1;
        csr_addr_write2csr = addr;
        csr_data_write2csr = data;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cur) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cur) begin
                check_eq({e.tag, "_missed"}, XLEN'(e.cyc), XLEN'(cur));
            end else begin
                case (e.kind)
                    KMtvec:  check_eq(e.tag, mtvec_o, e.val);
                    KMepc:   check_eq(e.tag, mepc_o, e.val);
                    default: check_eq(e.tag, csr_rdata_o, e.val);
                endcase
            end
        end
    end

    initial begin
        logic [XLEN-1:0] all_ones;
        all_ones = '1;
        rst_n = 1'b0;
        cycle_begin();
        cycle_begin();

        cycle_begin();
        rst_n = 1'b1;
        csr_addr_read_i = 12'h300;
        expect_val("rst_mstatus", KRdata, 64'h1800);
        expect_val("rst_mtvec_o", KMtvec, 64'h0);
        expect_val("rst_mepc_o", KMepc, 64'h0);

        cycle_begin();
        csr_addr_read_i = 12'hB00;
        expect_val("mcycle_first", KRdata, 64'd1);

        cycle_begin();
        csr_addr_read_i = 12'hB02;
        csr_write(12'h305, 64'h8000_0100);
        expect_val("minstret_idle", KRdata, 64'd0);
        expect_val("mtvec_o_bypass", KMtvec, 64'h8000_0100);

        cycle_begin();
        csr_addr_read_i = 12'h305;
        expect_val("mtvec_read", KRdata, 64'h8000_0100);
        expect_val("mtvec_o_held", KMtvec, 64'h8000_0100);

        cycle_begin();
        csr_addr_read_i = 12'h300;
        csr_write(12'h300, 64'h1808);
        expect_val("mstatus_wr_bypass", KRdata, 64'h1808);

        cycle_begin();
        wen_ecall2csr = 1'b1;
        wen_mstatus_ecall2csr = 1'b1;
        pc2csr = 64'h8000_0040;
        NO2csr = 64'd11;
        csr_addr_read_i = 12'h300;
        expect_val("ecall_mstatus", KRdata, 64'h1880);
        expect_val("ecall_mepc_o", KMepc, 64'h8000_0040);

        cycle_begin();
        wen_mstatus_mret2csr = 1'b1;
        csr_addr_read_i = 12'h342;
        expect_val("ecall_mcause", KRdata, 64'd11);
        expect_val("mret_mepc_o", KMepc, 64'h8000_0040);

        cycle_begin();
        csr_addr_read_i = 12'h300;
        expect_val("mret_mstatus", KRdata, 64'h1888);

        cycle_begin();
        csr_addr_read_i = 12'h341;
        expect_val("ecall_mepc", KRdata, 64'h8000_0040);

        cycle_begin();
        wen_ecall2csr = 1'b1;
        pc2csr = 64'h10;
        NO2csr = 64'd11;
        csr_write(12'h341, 64'h20);
        csr_addr_read_i = 12'h341;
        expect_val("prio_mepc", KRdata, 64'h10);
        expect_val("prio_mepc_o", KMepc, 64'h10);

        cycle_begin();
        wen_ecall2csr = 1'b1;
        pc2csr = 64'h10;
        NO2csr = 64'd11;
        csr_write(12'h342, 64'd5);
        csr_addr_read_i = 12'h342;
        expect_val("prio_mcause", KRdata, 64'd11);

        cycle_begin();
        csr_write(12'h305, 64'h44);
        retire_i = 1'b1;
        csr_addr_read_i = 12'h305;
        expect_val("mtvec_same_cycle", KRdata, 64'h44);
        expect_val("mtvec_o_44", KMtvec, 64'h44);

        cycle_begin();
        csr_write(12'h7C0, 64'hDEAD);
        csr_addr_read_i = 12'h7C0;
        expect_val("unmapped_read", KRdata, 64'h0);

        cycle_begin();
        csr_addr_read_i = 12'hB02;
        expect_val("minstret_one", KRdata, 64'd1);

        cycle_begin();
        csr_write(12'hB00, all_ones);
        csr_addr_read_i = 12'hB00;
        expect_val("mcycle_wr_bypass", KRdata, all_ones);

        cycle_begin();
        csr_addr_read_i = 12'hB00;
        expect_val("mcycle_max", KRdata, all_ones);

        cycle_begin();
        csr_addr_read_i = 12'hB00;
        expect_val("mcycle_wrap0", KRdata, 64'd0);

        cycle_begin();
        csr_addr_read_i = 12'hB00;
        expect_val("mcycle_wrap1", KRdata, 64'd1);

        cycle_begin();
        wen_mstatus_ecall2csr = 1'b1;
        wen_mstatus_mret2csr = 1'b1;
        csr_addr_read_i = 12'h300;
        expect_val("ecall_over_mret", KRdata, 64'h1880);

        cycle_begin();
        csr_write(12'hB02, 64'd5);
        retire_i = 1'b1;
        csr_addr_read_i = 12'hB02;
        expect_val("minstret_load", KRdata, 64'd5);

        cycle_begin();
        csr_addr_read_i = 12'hB02;
        expect_val("minstret_held", KRdata, 64'd5);

        cycle_begin();
        csr_write(12'h300, 64'hFF);
        wen_mstatus_ecall2csr = 1'b1;
        csr_addr_read_i = 12'h300;
        expect_val("mstatus_trap_prio", KRdata, 64'h1800);

        cycle_begin();
        rst_n = 1'b0;
        csr_write(12'h305, 64'h999);
        retire_i = 1'b1;

        cycle_begin();
        rst_n = 1'b1;
        csr_addr_read_i = 12'h305;
        expect_val("rst_mid_mtvec", KRdata, 64'h0);
        expect_val("rst_mid_mepc_o", KMepc, 64'h0);

        cycle_begin();
        csr_addr_read_i = 12'hB00;
        expect_val("rst_mid_mcycle", KRdata, 64'd1);

        cycle_begin();
        csr_addr_read_i = 12'hB02;
        expect_val("rst_mid_minstret", KRdata, 64'd0);

        cycle_begin();
        csr_addr_read_i = 12'h300;
        expect_val("rst_mid_mstatus", KRdata, 64'h1800);

        cycle_begin();
        check_eq("sb_drain", XLEN'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
